// File: rtl/race_sequencer_if.sv
// Race sequencer signal bundle.
// Groups the track/frame/lap event inputs and the race-flow outputs that
// feed lap_timer, car_ctl and the HUD stages.
//   track_visible   : level, track screen shown (into sequencer)
//   frame_ended     : one-pclk pulse per frame (into sequencer)
//   lap_finished    : one-pclk pulse per completed lap (into sequencer)
//   lap_timer_start : level enable to lap_timer
//   car_enable      : level gate for car_ctl key input
//   countdown_digit : digit shown during countdown, 0 when none
//   go_visible      : HUD shows "GO"
//   current_lap     : lap in progress (1-based), 0 before start
//   race_finished   : level, race complete
//   state           : IDLE=0, COUNTDOWN=1, RACING=2, FINISHED=3
// The sequencer uses the slave modport; the event source uses master.
interface race_sequencer_if #(
  parameter int LAP_W = 4
);
  logic             track_visible;
  logic             frame_ended;
  logic             lap_finished;
  logic             lap_timer_start;
  logic             car_enable;
  logic [3:0]       countdown_digit;
  logic             go_visible;
  logic [LAP_W-1:0] current_lap;
  logic             race_finished;
  logic [1:0]       state;

  modport master (
    output track_visible, frame_ended, lap_finished,
    input  lap_timer_start, car_enable, countdown_digit, go_visible,
           current_lap, race_finished, state
  );

  modport slave (
    input  track_visible, frame_ended, lap_finished,
    output lap_timer_start, car_enable, countdown_digit, go_visible,
           current_lap, race_finished, state
  );
endinterface

// File: rtl/race_sequencer.sv
// Race-flow controller.
// On track entry runs a frame-paced countdown (COUNT_FROM..1, then GO),
// enables the car and lap timer, counts laps and declares the race finished
// after TOTAL_LAPS. Dropping track_visible aborts back to IDLE at any time.
// Ports:
//   pclk : pixel clock, all logic on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : race_sequencer_if slave modport (events in, race status out)
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.
module race_sequencer #(
  parameter int FRAMES_PER_STEP = 60,
  parameter int COUNT_FROM      = 3,
  parameter int GO_HOLD_FRAMES  = 60,
  parameter int TOTAL_LAPS      = 3,
  parameter int LAP_W           = 4
) (
  input  logic                pclk,
  input  logic                rst,
  race_sequencer_if.slave     bus
);

  localparam int CNT_MAX = (FRAMES_PER_STEP > GO_HOLD_FRAMES) ? FRAMES_PER_STEP : GO_HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] GO_LAST     = CNT_W'(GO_HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       DIGIT_FIRST = 4'(COUNT_FROM);
  localparam logic [LAP_W-1:0] LAP_LAST    = LAP_W'(TOTAL_LAPS);
  localparam logic [LAP_W-1:0] LAP_ONE     = LAP_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACING    = 2'd2,
    FINISHED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]       digit_q, digit_d;
  logic             go_q, go_d;
  logic             timer_q, timer_d;
  logic             car_q, car_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             fin_q, fin_d;

  // Next-state and next-output logic. The abort on a dropped track_visible
  // is checked first so it overrides any frame or lap event in that cycle.
  // frame_cnt paces the countdown steps and is then reused to time how
  // long "GO" stays on screen.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    digit_d     = digit_q;
    go_d        = go_q;
    timer_d     = timer_q;
    car_d       = car_q;
    lap_d       = lap_q;
    fin_d       = fin_q;

    if (state_q != IDLE && !bus.track_visible) begin
      state_d     = IDLE;
      frame_cnt_d = '0;
      digit_d     = '0;
      go_d        = 1'b0;
      timer_d     = 1'b0;
      car_d       = 1'b0;
      lap_d       = '0;
      fin_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.track_visible) begin
            state_d     = COUNTDOWN;
            digit_d     = DIGIT_FIRST;
            frame_cnt_d = '0;
            lap_d       = '0;
          end
        end

        COUNTDOWN: begin
          if (bus.frame_ended) begin
            if (frame_cnt_q == STEP_LAST) begin
              frame_cnt_d = '0;
              if (digit_q > 4'd1) begin
                digit_d = digit_q - 4'd1;
              end else begin
                state_d = RACING;
                digit_d = '0;
                go_d    = 1'b1;
                timer_d = 1'b1;
                car_d   = 1'b1;
                lap_d   = LAP_ONE;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_ONE;
            end
          end
        end

        RACING: begin
          // The GO timer only runs while GO is shown, so the counter stops
          // at zero afterwards and never wraps.
          if (bus.frame_ended && go_q) begin
            if (frame_cnt_q == GO_LAST) begin
              go_d        = 1'b0;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_ONE;
            end
          end
          // Placed after the frame handling so finishing also forces GO off.
          if (bus.lap_finished) begin
            if (lap_q < LAP_LAST) begin
              lap_d = lap_q + LAP_ONE;
            end else begin
              state_d = FINISHED;
              fin_d   = 1'b1;
              car_d   = 1'b0;
              timer_d = 1'b0;
              go_d    = 1'b0;
            end
          end
        end

        FINISHED: begin
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      digit_q     <= '0;
      go_q        <= 1'b0;
      timer_q     <= 1'b0;
      car_q       <= 1'b0;
      lap_q       <= '0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      digit_q     <= digit_d;
      go_q        <= go_d;
      timer_q     <= timer_d;
      car_q       <= car_d;
      lap_q       <= lap_d;
      fin_q       <= fin_d;
    end
  end

  assign bus.state           = state_q;
  assign bus.countdown_digit = digit_q;
  assign bus.go_visible      = go_q;
  assign bus.lap_timer_start = timer_q;
  assign bus.car_enable      = car_q;
  assign bus.current_lap     = lap_q;
  assign bus.race_finished   = fin_q;

endmodule
